// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button conditioner.
package btn_pkg;

  typedef enum logic [2:0] {IDLE, PRESS_DB, HELD, REPEAT, REL_DB} btn_state_t;

  function automatic int btn_cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM, hold/repeat timer.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int HOLD_CYC     = 25_000_000,
  parameter int REPEAT_CYC   = 5_000_000,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam int HMAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int CW   = btn_cnt_w(DEBOUNCE_CYC);
  localparam int HW   = btn_cnt_w(HMAX);

  localparam logic          REL_LVL   = ACTIVE_LOW;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYC - 1);
  localparam logic [HW-1:0] HOLD_DUE  = HW'(HOLD_CYC);
  localparam logic [HW-1:0] REP_DUE   = HW'(REPEAT_CYC);

  logic          sync1_q, sync2_q;
  logic          s;
  btn_state_t    state_q, state_d, ret_q, ret_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          repeat_q, repeat_d;
  logic [HW-1:0] hlast, hdue;

  assign s = ACTIVE_LOW ? ~sync2_q : sync2_q;

  // cnt holds the stable samples already seen, so the current sample closes
  // the window at DEBOUNCE_CYC-1. hcnt counts every HELD/REPEAT cycle; a count
  // that falls due while the release is being debounced fires on the return.
  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    hlast     = (state_q == HELD) ? HOLD_LAST : REP_LAST;
    hdue      = (ret_q == HELD) ? HOLD_DUE : REP_DUE;
    case (state_q)
      IDLE: begin
        if (s) begin
          if (DEBOUNCE_CYC == 1) begin
            state_d = HELD;
            level_d = 1'b1;
            press_d = 1'b1;
            hcnt_d  = '0;
            cnt_d   = '0;
          end else begin
            state_d = PRESS_DB;
            cnt_d   = CNT_ONE;
          end
        end
      end
      PRESS_DB: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = HELD;
          level_d = 1'b1;
          press_d = 1'b1;
          hcnt_d  = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD, REPEAT: begin
        if (!s) begin
          if (DEBOUNCE_CYC == 1) begin
            state_d   = IDLE;
            level_d   = 1'b0;
            release_d = 1'b1;
            hcnt_d    = '0;
          end else begin
            state_d = REL_DB;
            ret_d   = state_q;
            cnt_d   = CNT_ONE;
            hcnt_d  = hcnt_q + HW'(1);
          end
        end else if (hcnt_q == hlast) begin
          state_d  = REPEAT;
          repeat_d = 1'b1;
          hcnt_d   = '0;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      REL_DB: begin
        if (s) begin
          cnt_d = '0;
          if (hcnt_q == hdue) begin
            state_d  = REPEAT;
            repeat_d = 1'b1;
            hcnt_d   = '0;
          end else begin
            state_d = ret_q;
          end
        end else if (cnt_q == DB_LAST) begin
          state_d   = IDLE;
          level_d   = 1'b0;
          release_d = 1'b1;
          cnt_d     = '0;
          hcnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= REL_LVL;
      sync2_q   <= REL_LVL;
      state_q   <= IDLE;
      ret_q     <= IDLE;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      ret_q     <= ret_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_repeat  = repeat_q;

endmodule

// File: rtl/btn_debounce_rpt.sv
// Multi-channel button conditioner: independent channels plus the
// press-or-repeat stepping output for the downstream display stage.
module btn_debounce_rpt
  import btn_pkg::*;
#(
  parameter int N_BTN        = 2,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int HOLD_CYC     = 25_000_000,
  parameter int REPEAT_CYC   = 5_000_000,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic [N_BTN-1:0] btn_evt
);

  for (genvar ch = 0; ch < N_BTN; ch++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .HOLD_CYC    (HOLD_CYC),
      .REPEAT_CYC  (REPEAT_CYC),
      .ACTIVE_LOW  (ACTIVE_LOW)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .btn_raw    (btn_raw[ch]),
      .btn_level  (btn_level[ch]),
      .btn_press  (btn_press[ch]),
      .btn_release(btn_release[ch]),
      .btn_repeat (btn_repeat[ch])
    );
  end

  assign btn_evt = btn_press | btn_repeat;

endmodule

// File: tb/tb_btn_debounce_rpt.sv
// Scoreboard bench for btn_debounce_rpt: a sample-level reference model
// predicts every output cycle; a monitor compares the DUT against it.
module tb_btn_debounce_rpt;

  localparam int NB = 2;
  localparam int DB = 4;
  localparam int HC = 20;
  localparam int RC = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn_raw = '1;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeat, btn_evt;

  btn_debounce_rpt #(
    .N_BTN(NB), .DEBOUNCE_CYC(DB), .HOLD_CYC(HC), .REPEAT_CYC(RC), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(btn_level),
    .btn_press(btn_press), .btn_release(btn_release), .btn_repeat(btn_repeat),
    .btn_evt(btn_evt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NB-1:0] level;
    logic [NB-1:0] press;
    logic [NB-1:0] rel;
    logic [NB-1:0] rpt;
    logic [NB-1:0] evt;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   pushed = 0;
  int   popped = 0;
  int   cyc = 0;

  int            press0_log[$];
  int            rel0_log[$];
  int            rep0_log[$];
  logic [NB-1:0] press_vec_log[$];

  // Reference model: pressed-level pipeline plus run/elapsed bookkeeping.
  bit p0[NB], p1[NB], lvl[NB];
  int run[NB], el[NB], tgt[NB];

  always @(posedge clk) cyc++;

  task automatic modelStep(input logic [NB-1:0] pr, input bit r);
    exp_t e;
    e = '0;
    if (r) begin
      for (int ch = 0; ch < NB; ch++) begin
        p0[ch] = 0; p1[ch] = 0; lvl[ch] = 0; run[ch] = 0; el[ch] = 0; tgt[ch] = HC;
      end
    end else begin
      for (int ch = 0; ch < NB; ch++) begin
        bit smp;
        smp = p1[ch];
        if (!lvl[ch]) begin
          if (smp) begin
            run[ch]++;
            if (run[ch] == DB) begin
              lvl[ch] = 1; e.press[ch] = 1'b1; run[ch] = 0; el[ch] = 0; tgt[ch] = HC;
            end
          end else begin
            run[ch] = 0;
          end
        end else if (run[ch] == 0) begin
          el[ch]++;
          if (!smp) begin
            run[ch] = 1;
            if (run[ch] == DB) begin
              lvl[ch] = 0; e.rel[ch] = 1'b1; run[ch] = 0;
            end
          end else if (el[ch] >= tgt[ch]) begin
            e.rpt[ch] = 1'b1; el[ch] = 0; tgt[ch] = RC;
          end
        end else begin
          if (smp) begin
            run[ch] = 0;
            if (el[ch] >= tgt[ch]) begin
              e.rpt[ch] = 1'b1; el[ch] = 0; tgt[ch] = RC;
            end
          end else begin
            run[ch]++;
            if (run[ch] == DB) begin
              lvl[ch] = 0; e.rel[ch] = 1'b1; run[ch] = 0;
            end
          end
        end
        p1[ch] = p0[ch];
        p0[ch] = pr[ch];
        e.level[ch] = lvl[ch];
      end
      e.evt = e.press | e.rpt;
    end
    exp_q.push_back(e);
    pushed++;
  endtask

  task automatic applyStimulus(input logic [NB-1:0] pr, input bit r);
    @(negedge clk);
    rst     = r;
    btn_raw = ~pr;
    modelStep(pr, r);
  endtask

  task automatic driveFor(input logic [NB-1:0] pr, input int n);
    for (int i = 0; i < n; i++) applyStimulus(pr, 1'b0);
  endtask

  task automatic checkOutput(input exp_t e);
    exp_t got;
    got = {btn_level, btn_press, btn_release, btn_repeat, btn_evt};
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("[TB] FAIL outputs @%0d: got lvl=%b prs=%b rel=%b rpt=%b evt=%b, want lvl=%b prs=%b rel=%b rpt=%b evt=%b",
               cyc, got.level, got.press, got.rel, got.rpt, got.evt,
               e.level, e.press, e.rel, e.rpt, e.evt);
    end
  endtask

  task automatic checkValue(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic clearLogs();
    press0_log.delete(); rel0_log.delete(); rep0_log.delete(); press_vec_log.delete();
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      popped++;
      checkOutput(exp_q.pop_front());
      if (btn_press[0] === 1'b1)   press0_log.push_back(cyc);
      if (btn_release[0] === 1'b1) rel0_log.push_back(cyc);
      if (btn_repeat[0] === 1'b1)  rep0_log.push_back(cyc);
      if (|btn_press)              press_vec_log.push_back(btn_press);
    end
  end

  initial begin
    int            c0, cr;
    int            dur[NB];
    logic [NB-1:0] cur;

    applyStimulus('0, 1'b1);
    applyStimulus('0, 1'b1);
    driveFor('0, 5);

    // Clean press on channel 0
    clearLogs();
    c0 = cyc + 1;
    driveFor(2'b01, 15);
    driveFor('0, 12);
    checkValue("clean_press_count", press0_log.size(), 1);
    if (press0_log.size() >= 1) checkValue("clean_press_cycle", press0_log[0] - c0, 6);
    checkValue("clean_repeat_count", rep0_log.size(), 0);
    checkValue("clean_release_count", rel0_log.size(), 1);

    // Bounce shorter than the debounce window
    clearLogs();
    for (int i = 0; i < 5; i++) begin
      driveFor(2'b01, 2);
      driveFor('0, 2);
    end
    driveFor('0, 10);
    checkValue("bounce_events", press0_log.size() + rel0_log.size() + rep0_log.size(), 0);

    // Auto-repeat
    clearLogs();
    c0 = cyc + 1;
    driveFor(2'b01, 60);
    driveFor('0, 10);
    checkValue("ar_press_count", press0_log.size(), 1);
    if (press0_log.size() >= 1) checkValue("ar_press_cycle", press0_log[0] - c0, 6);
    checkValue("ar_repeat_count", rep0_log.size(), 5);
    for (int i = 0; i < rep0_log.size() && i < 5; i++)
      checkValue("ar_repeat_cycle", rep0_log[i] - c0, 26 + 8 * i);
    checkValue("ar_release_count", rel0_log.size(), 1);
    if (rel0_log.size() >= 1) checkValue("ar_release_cycle", rel0_log[0] - c0, 66);

    // Release glitch during REPEAT
    clearLogs();
    c0 = cyc + 1;
    driveFor(2'b01, 38);
    driveFor('0, 3);
    driveFor(2'b01, 20);
    driveFor('0, 10);
    checkValue("glitch_repeat_count", rep0_log.size(), 5);
    if (rep0_log.size() >= 3) checkValue("glitch_delayed_repeat", rep0_log[2] - c0, 45);
    checkValue("glitch_release_count", rel0_log.size(), 1);
    if (rel0_log.size() >= 1) checkValue("glitch_release_cycle", rel0_log[0] - c0, 67);

    // Simultaneous channels
    clearLogs();
    driveFor(2'b11, 50);
    driveFor('0, 10);
    checkValue("simul_press_events", press_vec_log.size(), 1);
    if (press_vec_log.size() >= 1) checkValue("simul_press_vec", int'(press_vec_log[0]), 3);

    // Reset while held
    clearLogs();
    driveFor(2'b01, 15);
    cr = cyc + 1;
    applyStimulus(2'b01, 1'b1);
    driveFor(2'b01, 15);
    driveFor('0, 12);
    checkValue("rst_press_count", press0_log.size(), 2);
    if (press0_log.size() >= 2) checkValue("rst_repress_cycle", press0_log[1] - cr, 7);
    checkValue("rst_release_count", rel0_log.size(), 1);

    // Randomised levels with occasional bounce and reset
    for (int ch = 0; ch < NB; ch++) dur[ch] = 0;
    cur = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int ch = 0; ch < NB; ch++) begin
        if (dur[ch] == 0) begin
          cur[ch] = 1'($urandom_range(0, 1));
          dur[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 60));
        end
        dur[ch]--;
      end
      applyStimulus(cur, $urandom_range(0, 599) == 0);
    end
    driveFor('0, 12);

    @(posedge clk);
    #2;
    checkValue("scoreboard_drain", exp_q.size(), 0);
    checkValue("scoreboard_pops", popped, pushed);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
